// File: rtl/csr_arb_pkg.sv
// Shared CSR bus widths, arbiter state encoding and default write-lock base.
// Used by the arbiter, the I2C slave and the register file.
package csr_arb_pkg;

    localparam int CSR_ADDR_W = 5;
    localparam int CSR_DATA_W = 8;

    localparam logic [CSR_ADDR_W-1:0] LOCK_BASE_DEF = 5'h18;

    typedef enum logic [1:0] {
        IDLE,
        P1_ACC,
        P1_ACK
    } arb_state_t;

endpackage

// File: rtl/csr_arbiter.sv
// Two-master CSR bus arbiter: port 0 (I2C slave) never stalls, port 1 gets
// single-beat request/ack slots. Optional macro: CSR_ARB_WRITE_LOCK_EN.
import csr_arb_pkg::*;

module csr_arbiter #(
    parameter int                ADDR_W    = CSR_ADDR_W,
    parameter int                DATA_W    = CSR_DATA_W,
    parameter logic [ADDR_W-1:0] LOCK_BASE = LOCK_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_a,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_do,
    output logic [DATA_W-1:0] p0_di,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_a,
    input  logic [DATA_W-1:0] p1_do,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_di,
    output logic              p1_err,
    output logic [ADDR_W-1:0] csr_a,
    output logic              csr_we,
    output logic [DATA_W-1:0] csr_do,
    input  logic [DATA_W-1:0] csr_di
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] p0_di_q, p0_di_d;
    logic [DATA_W-1:0] p1_di_q, p1_di_d;
    logic              p1_ack_q, p1_ack_d;
    logic              p1_err_q, p1_err_d;
    logic              p1_sel;
    logic              p1_lock;

`ifdef CSR_ARB_WRITE_LOCK_EN
    // Port 1 writes into the protected window are dropped but still acked.
    always_comb begin
        p1_lock = p1_we && (p1_a >= LOCK_BASE);
    end
`else
    logic unused_lock_base;

    // Lock window is inert in this build.
    always_comb begin
        p1_lock          = 1'b0;
        unused_lock_base = ^LOCK_BASE;
    end
`endif

    // Downstream mux: port 0 writes always win, port 1 only in its access slot.
    always_comb begin
        p1_sel = (state_q == P1_ACC) && p1_req && !p0_we;
        if (p1_sel) begin
            csr_a  = p1_a;
            csr_we = p1_we && !p1_lock;
            csr_do = p1_do;
        end else begin
            csr_a  = p0_a;
            csr_we = p0_we;
            csr_do = p0_do;
        end
        p0_di_d = p1_sel ? p0_di_q : csr_di;
    end

    // Next state; a request dropped mid-access aborts quietly to IDLE.
    always_comb begin
        state_d  = state_q;
        p1_di_d  = p1_di_q;
        p1_ack_d = 1'b0;
        p1_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p1_req) state_d = P1_ACC;
            end
            P1_ACC: begin
                if (!p1_req) begin
                    state_d = IDLE;
                end else if (!p0_we) begin
                    state_d  = P1_ACK;
                    p1_ack_d = 1'b1;
                    p1_err_d = p1_lock;
                    p1_di_d  = csr_di;
                end
            end
            P1_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p0_di_q  <= '0;
            p1_di_q  <= '0;
            p1_ack_q <= 1'b0;
            p1_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p0_di_q  <= p0_di_d;
            p1_di_q  <= p1_di_d;
            p1_ack_q <= p1_ack_d;
            p1_err_q <= p1_err_d;
        end
    end

    assign p0_di  = p0_di_q;
    assign p1_di  = p1_di_q;
    assign p1_ack = p1_ack_q;
    assign p1_err = p1_err_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: register-file model plus a port 1 result scoreboard.
// Honours CSR_ARB_WRITE_LOCK_EN when defined.
module tb_csr_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] p0_a;
    logic       p0_we;
    logic [7:0] p0_do;
    logic [7:0] p0_di;
    logic       p1_req;
    logic       p1_we;
    logic [4:0] p1_a;
    logic [7:0] p1_do;
    logic       p1_ack;
    logic [7:0] p1_di;
    logic       p1_err;
    logic [4:0] csr_a;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] csr_di;

    logic [7:0] regs [0:31];
    logic       ld_en;
    logic [4:0] ld_a;
    logic [7:0] ld_d;

    typedef struct {
        logic [7:0] di;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   passed;

    csr_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .p0_a   (p0_a),
        .p0_we  (p0_we),
        .p0_do  (p0_do),
        .p0_di  (p0_di),
        .p1_req (p1_req),
        .p1_we  (p1_we),
        .p1_a   (p1_a),
        .p1_do  (p1_do),
        .p1_ack (p1_ack),
        .p1_di  (p1_di),
        .p1_err (p1_err),
        .csr_a  (csr_a),
        .csr_we (csr_we),
        .csr_do (csr_do),
        .csr_di (csr_di)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: combinational read, write on the rising edge.
    assign csr_di = regs[csr_a];

    always @(posedge clk) begin
        if (ld_en) regs[ld_a] <= ld_d;
        else if (csr_we) regs[csr_a] <= csr_do;
    end

    // Scoreboard: every ack consumes the oldest expected port 1 result.
    always @(negedge clk) begin
        if (p1_ack === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_ack: p1_ack=1 with no request outstanding");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (p1_di !== e.di || p1_err !== e.err)
                    $display("FAIL p1_result: di=%h err=%b, want di=%h err=%b",
                             p1_di, p1_err, e.di, e.err);
                else
                    passed++;
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic p1_xfer(input logic we, input logic [4:0] a,
                           input logic [7:0] d, input logic [7:0] edi,
                           input logic eerr);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        p1_req = 1'b1;
        p1_we  = we;
        p1_a   = a;
        p1_do  = d;
        sb.push_back('{edi, eerr});
        do begin
            @(negedge clk);
            lat++;
        end while (p1_ack !== 1'b1 && lat < 20);
        checks++;
        if (lat !== 3)
            $display("FAIL p1_latency: ack at cycle %0d, want cycle 3", lat);
        else
            passed++;
        p1_req = 1'b0;
        p1_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        p0_a   = 5'd3;
        p0_we  = 1'b0;
        p0_do  = 8'h00;
        p1_req = 1'b0;
        p1_we  = 1'b0;
        p1_a   = 5'd0;
        p1_do  = 8'h00;
        ld_en  = 1'b0;
        ld_a   = 5'd0;
        ld_d   = 8'h00;
        @(posedge clk);
        #1;
        preload(5'd3, 8'h5A);
        preload(5'd7, 8'hC3);
        preload(5'd5, 8'hA5);
        preload(5'd2, 8'h00);
        preload(5'd9, 8'h00);
        preload(5'h1A, 8'h77);
        preload(5'h17, 8'h00);
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b0 || p1_err !== 1'b0 || p1_di !== 8'h00 ||
            p0_di !== 8'h00 || csr_we !== 1'b0)
            $display("FAIL reset_vals: ack=%b err=%b p1_di=%h p0_di=%h we=%b, want 0",
                     p1_ack, p1_err, p1_di, p0_di, csr_we);
        else
            passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (p0_di !== 8'h5A || csr_we !== 1'b0 || csr_a !== 5'd3)
            $display("FAIL idle_refresh: p0_di=%h we=%b a=%h, want 5a 0 03",
                     p0_di, csr_we, csr_a);
        else
            passed++;
    endtask

    task automatic test_p1_read();
        @(posedge clk);
        #1;
        p1_req = 1'b1;
        p1_we  = 1'b0;
        p1_a   = 5'd7;
        sb.push_back('{8'hC3, 1'b0});
        @(posedge clk);
        #1;
        p0_a = 5'd5;
        @(negedge clk);
        checks++;
        if (csr_a !== 5'd7 || csr_we !== 1'b0)
            $display("FAIL read_bus: csr_a=%h we=%b, want 07 0", csr_a, csr_we);
        else
            passed++;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b1 || p0_di !== 8'h5A)
            $display("FAIL read_ack_hold: ack=%b p0_di=%h, want 1 5a", p1_ack, p0_di);
        else
            passed++;
        p1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b0 || p0_di !== 8'hA5)
            $display("FAIL read_after: ack=%b p0_di=%h, want 0 a5", p1_ack, p0_di);
        else
            passed++;
    endtask

    task automatic test_collision();
        @(posedge clk);
        #1;
        p1_req = 1'b1;
        p1_we  = 1'b1;
        p1_a   = 5'd2;
        p1_do  = 8'h11;
        sb.push_back('{8'h00, 1'b0});
        @(posedge clk);
        #1;
        p0_we = 1'b1;
        p0_a  = 5'd9;
        p0_do = 8'h22;
        @(negedge clk);
        checks++;
        if (csr_a !== 5'd9 || csr_we !== 1'b1 || csr_do !== 8'h22)
            $display("FAIL p0_priority: a=%h we=%b do=%h, want 09 1 22",
                     csr_a, csr_we, csr_do);
        else
            passed++;
        @(posedge clk);
        #1;
        p0_we = 1'b0;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b0 || csr_a !== 5'd2 || csr_we !== 1'b1 ||
            csr_do !== 8'h11 || regs[9] !== 8'h22 || regs[2] !== 8'h00)
            $display("FAIL retry_cycle: ack=%b a=%h we=%b do=%h r9=%h r2=%h",
                     p1_ack, csr_a, csr_we, csr_do, regs[9], regs[2]);
        else
            passed++;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b1 || regs[2] !== 8'h11)
            $display("FAIL delayed_ack: ack=%b r2=%h, want 1 11", p1_ack, regs[2]);
        else
            passed++;
        p1_req = 1'b0;
        p1_we  = 1'b0;
    endtask

    task automatic test_lock();
        logic [7:0] want1a;
        logic       err1a;
`ifdef CSR_ARB_WRITE_LOCK_EN
        want1a = 8'h77;
        err1a  = 1'b1;
`else
        want1a = 8'h55;
        err1a  = 1'b0;
`endif
        p1_xfer(1'b1, 5'h1A, 8'h55, 8'h77, err1a);
        checks++;
        if (regs[5'h1A] !== want1a)
            $display("FAIL lock_1a: reg=%h, want %h", regs[5'h1A], want1a);
        else
            passed++;
        p1_xfer(1'b1, 5'h17, 8'h66, 8'h00, 1'b0);
        checks++;
        if (regs[5'h17] !== 8'h66)
            $display("FAIL lock_17: reg=%h, want 66", regs[5'h17]);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        int         last;
        int         n;
        logic       chk;
        logic [7:0] want;
        last = -1;
        n    = 0;
        chk  = 1'b0;
        want = 8'h00;
        @(posedge clk);
        #1;
        p1_req = 1'b1;
        p1_we  = 1'b0;
        p1_a   = 5'd7;
        sb.push_back('{8'hC3, 1'b0});
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (chk) begin
                checks++;
                if (p0_di !== want)
                    $display("FAIL b2b_refresh: p0_di=%h, want %h", p0_di, want);
                else
                    passed++;
                chk = 1'b0;
            end
            if (p1_ack === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 3)
                        $display("FAIL b2b_spacing: %0d cycles, want 3", cyc - last);
                    else
                        passed++;
                end
                last = cyc;
                n++;
                if (n == 3) begin
                    p1_req = 1'b0;
                end else begin
                    p1_a = (n % 2 == 1) ? 5'd5 : 5'd7;
                    sb.push_back('{(n % 2 == 1) ? 8'hA5 : 8'hC3, 1'b0});
                end
                p0_a = (n % 2 == 1) ? 5'd3 : 5'd9;
                want = (n % 2 == 1) ? 8'h5A : 8'h22;
                chk  = 1'b1;
            end
            if (n == 3 && !chk) break;
        end
        checks++;
        if (n !== 3)
            $display("FAIL b2b_count: %0d acks, want 3", n);
        else
            passed++;
        p1_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        p1_req = 1'b1;
        p1_we  = 1'b0;
        p1_a   = 5'd5;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b0 || p1_err !== 1'b0 || p1_di !== 8'h00 ||
            p0_di !== 8'h00 || csr_we !== 1'b0)
            $display("FAIL reset_mid: ack=%b err=%b p1_di=%h p0_di=%h we=%b, want 0",
                     p1_ack, p1_err, p1_di, p0_di, csr_we);
        else
            passed++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p1_ack === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL reset_no_ack: ack seen=%b, want 0", seen);
        else
            passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_p1_read();
        test_collision();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0)
            $display("FAIL sb_drain: %0d results pending, want 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
# csr_arbiter

- Shares the single 32×8 CSR register-file bus between two masters.
  - Port 0 is the I2C slave. It has no handshake and can never stall.
  - Port 1 is a generic request/acknowledge master, e.g. a board-management or debug engine.
- Sits between both masters and the register file; owns the downstream `csr_*` bus.
- Port 0 has absolute write priority and a continuously refreshed read-data register. Port 1 gets single-beat, non-preemptive transactions in the remaining cycles.

## Interface
Parameters:
- `ADDR_W`, 5, CSR address width.
- `DATA_W`, 8, CSR data width.
- `LOCK_BASE`, 5'h18, lowest address protected from port 1 writes (only with `CSR_ARB_WRITE_LOCK_EN`).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_a`  in  ADDR_W  port 0 address; held stable for many cycles.
- `p0_we`  in  1  port 0 one-cycle write strobe.
- `p0_do`  in  DATA_W  port 0 write data.
- `p0_di`  out  DATA_W  port 0 read data (registered).
- `p1_req`  in  1  port 1 request; held high with `p1_we`/`p1_a`/`p1_do` stable until `p1_ack`.
- `p1_we`  in  1  port 1 transaction is a write.
- `p1_a`  in  ADDR_W  port 1 address.
- `p1_do`  in  DATA_W  port 1 write data.
- `p1_ack`  out  1  one-cycle completion pulse.
- `p1_di`  out  DATA_W  port 1 read data; valid in the `p1_ack` cycle, held until the next ack.
- `p1_err`  out  1  pulses with `p1_ack` when a write was dropped; constant 0 without the macro.
- `csr_a`  out  ADDR_W  downstream address.
- `csr_we`  out  1  downstream write strobe.
- `csr_do`  out  DATA_W  downstream write data.
- `csr_di`  in  DATA_W  downstream read data; combinational from `csr_a`.

## Operation
States:
- IDLE: port 0 owns the bus.
- P1_ACC: port 1 owns the bus.
- P1_ACK: completion cycle.

Bus ownership per cycle:
- If `p0_we` is high, in any state: `csr_a`=`p0_a`, `csr_we`=1, `csr_do`=`p0_do`. Port 0 writes are never dropped or delayed.
- Otherwise, in P1_ACC: `csr_a`=`p1_a`, `csr_we`=`p1_we`, `csr_do`=`p1_do`.
- Otherwise, in IDLE or P1_ACK: `csr_a`=`p0_a`, `csr_we`=0.

`p0_di` refresh:
- `p0_di` <= `csr_di` on every cycle in which `csr_a`=`p0_a`.
- `p0_di` holds its value while port 1 owns the bus.

State transitions:
- IDLE -> P1_ACC when `p1_req`=1.
- P1_ACC -> P1_ACK when `p0_we`=0. Port 1 is served in that cycle and `p1_di` <= `csr_di`.
- P1_ACC stays in P1_ACC when `p0_we`=1; port 1 is retried next cycle.
- P1_ACK -> IDLE unconditionally. `p1_ack`=1 in this state.
- The P1_ACK cycle guarantees at least one port 0 refresh between consecutive port 1 grants.

Arithmetic: no address arithmetic; muxing only; widths are `ADDR_W`/`DATA_W` throughout.

## Timing
- Reset values: state=IDLE, `p1_ack`=0, `p1_err`=0, `p1_di`=0, `p0_di`=0. `csr_we`=0 unless `p0_we` is high.
- Port 1 minimum latency: `p1_req` high in cycle N → access in N+1 → `p1_ack` in N+2.
  - Each colliding `p0_we` adds one cycle.
- Port 1 throughput: at most one transaction per 3 cycles.
- Port 0 read staleness: at most 2 cycles after `p0_a` changes. The I2C bit period keeps this invisible.
- `p1_req` dropped before ack: protocol violation. Behaviour is undefined but must not hang; the FSM still reaches IDLE within 2 cycles.
- Reset mid-transaction: no `p1_ack` is issued; the requester must re-request.
- `p1_req` high and `p0_we` high in IDLE: the port 0 write happens, and the FSM still moves to P1_ACC.

## Configuration
- `CSR_ARB_WRITE_LOCK_EN` defined:
  - A port 1 write with `p1_a` >= `LOCK_BASE` drives `csr_we`=0 in its access cycle.
  - It still completes with `p1_ack`=1 and `p1_err`=1.
  - Port 1 reads and all port 0 accesses are unaffected.
- Not defined: no lock check, and `p1_err` is tied 0.

## Structure
- Package `csr_arb_pkg` holds:
  - state enum (IDLE, P1_ACC, P1_ACK);
  - `CSR_ADDR_W`=5 and `CSR_DATA_W`=8, shared with the I2C slave and register file;
  - default `LOCK_BASE`.
- Flat module; no sub-module is warranted. The downstream mux and FSM live in one file.

## Test plan
- Reset, then idle with `p0_a`=3 and reg[3]=8'h5A → `p0_di`=8'h5A within 2 cycles; `csr_we`=0.
- Port 1 read of reg[7]=8'hC3 → `p1_ack` 2 cycles after `p1_req` with `p1_di`=8'hC3; `p0_di` holds its prior value during the access cycle.
- Port 1 write 8'h11 to reg[2], with `p0_we` pulsing 8'h22 to reg[9] in the P1_ACC cycle:
  - reg[9]=8'h22 is written first;
  - `p1_ack` is delayed by one cycle;
  - reg[2]=8'h11.
- Back-to-back `p1_req` held high → acks exactly 3 cycles apart; `p0_di` is refreshed in each P1_ACK/IDLE cycle.
- With `CSR_ARB_WRITE_LOCK_EN` and `LOCK_BASE`=5'h18:
  - port 1 write to 5'h1A → reg unchanged, `p1_ack`=`p1_err`=1;
  - write to 5'h17 → reg updated, `p1_err`=0.
- `rst` asserted while in P1_ACC → state IDLE next cycle, no `p1_ack`, all outputs at reset values.
